// File: rtl/gpio_port_pkg.sv
// Shared register map, bus widths and parameter legality checks for the Avalon GPIO port.
package gpio_port_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_DIR      = 3'd0;
    localparam logic [ADDR_W-1:0] REG_PIN      = 3'd1;
    localparam logic [ADDR_W-1:0] REG_PORT     = 3'd2;
    localparam logic [ADDR_W-1:0] REG_SET      = 3'd3;
    localparam logic [ADDR_W-1:0] REG_CLR      = 3'd4;
    localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd5;
    localparam logic [ADDR_W-1:0] REG_EDGE_CAP = 3'd6;
    localparam logic [ADDR_W-1:0] REG_EDGE_SEL = 3'd7;

    function automatic bit width_legal(input int unsigned w);
        return (w >= 1) && (w <= DATA_W);
    endfunction

    function automatic bit sync_stages_legal(input int unsigned s);
        return (s >= 2) && (s <= 4);
    endfunction

endpackage

// File: rtl/gpio_port_sync.sv
// Per-bit pin synchroniser with previous-value register and rise/fall detection.
// Edge outputs stay low until the chain has filled after reset, so pins high at reset never fire.
module gpio_port_sync
    import gpio_port_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] pin_sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned PrimeCount = SYNC_STAGES + 1;
    localparam int unsigned CntW       = $clog2(PrimeCount + 1);

    // Index 0 is the stage closest to the pins.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [CntW-1:0]                   prime_cnt_q;
    logic                              primed;

    assign primed = (prime_cnt_q == CntW'(PrimeCount));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q     <= '0;
            prev_q      <= '0;
            prime_cnt_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pins};
            prev_q  <= chain_q[SYNC_STAGES-1];
            if (!primed) begin
                prime_cnt_q <= prime_cnt_q + CntW'(1);
            end
        end
    end

    assign pin_sync = chain_q[SYNC_STAGES-1];
    assign rise     = primed ? (pin_sync & ~prev_q) : '0;
    assign fall     = primed ? (~pin_sync & prev_q) : '0;

endmodule

// File: rtl/avalon_gpio_port.sv
// Avalon-MM bidirectional GPIO port: direction/output latch, synchronised readback, edge capture.
// Define GPIO_PORT_IRQ_EN to build the IRQ_MASK register and the registered level interrupt.
module avalon_gpio_port
    import gpio_port_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_DIR   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic [WIDTH-1:0]  port_i,
    output logic [WIDTH-1:0]  port_o,
    output logic [WIDTH-1:0]  port_oe,
    output logic              irq
);

    if (!width_legal(WIDTH) || !sync_stages_legal(SYNC_STAGES)) begin : g_param_check
        $error("avalon_gpio_port: WIDTH must be 1..32 and SYNC_STAGES 2..4");
    end

    logic [WIDTH-1:0]  dir_q, dir_d;
    logic [WIDTH-1:0]  port_q, port_d;
    logic [WIDTH-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  w1c;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  pin_sync, rise, fall, edges;
    logic [WIDTH-1:0]  mask_rd;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_word;
    logic              unused_wdata;

    assign wd           = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    gpio_port_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .pins     (port_i),
        .pin_sync (pin_sync),
        .rise     (rise),
        .fall     (fall)
    );

    assign edges = (rise & ~sel_q) | (fall & sel_q);

    always_comb begin
        dir_d  = dir_q;
        port_d = port_q;
        sel_d  = sel_q;
        w1c    = '0;
        if (avs_write) begin
            case (avs_address)
                REG_DIR:      dir_d  = wd;
                REG_PORT:     port_d = wd;
                REG_SET:      port_d = port_q | wd;
                REG_CLR:      port_d = port_q & ~wd;
                REG_EDGE_CAP: w1c    = wd;
                REG_EDGE_SEL: sel_d  = wd;
                default:      ;
            endcase
        end
        // Set-dominant: a fresh edge wins over a simultaneous clear.
        cap_d = (cap_q & ~w1c) | edges;
    end

    // Readback uses current register values, so a same-cycle write is not yet visible.
    always_comb begin
        rd_word = '0;
        case (avs_address)
            REG_DIR:      rd_word[WIDTH-1:0] = dir_q;
            REG_PIN:      rd_word[WIDTH-1:0] = pin_sync;
            REG_PORT:     rd_word[WIDTH-1:0] = port_q;
            REG_IRQ_MASK: rd_word[WIDTH-1:0] = mask_rd;
            REG_EDGE_CAP: rd_word[WIDTH-1:0] = cap_q;
            REG_EDGE_SEL: rd_word[WIDTH-1:0] = sel_q;
            default:      rd_word            = '0;
        endcase
        rdata_d = avs_read ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q   <= RESET_DIR[WIDTH-1:0];
            port_q  <= '0;
            sel_q   <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            dir_q   <= dir_d;
            port_q  <= port_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef GPIO_PORT_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q;

    always_comb begin
        mask_d = mask_q;
        if (avs_write && (avs_address == REG_IRQ_MASK)) begin
            mask_d = wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(cap_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    assign avs_readdata = rdata_q;
    assign port_o       = port_q;
    assign port_oe      = dir_q;

endmodule

// File: tb/tb_avalon_gpio_port.sv
// Directed bench for avalon_gpio_port: per-cycle compare against a pin-history model plus literal checks.
`timescale 1ns/1ps
module tb_avalon_gpio_port;
    import gpio_port_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b1;
    logic [2:0]  avs_address   = '0;
    logic        avs_read      = 1'b0;
    logic        avs_write     = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [W-1:0] port_i       = '0;
    logic [31:0] avs_readdata, rd5, rd32;
    logic [W-1:0] port_o, port_oe;
    logic [4:0]  port_o5, port_oe5;
    logic [31:0] port_o32, port_oe32;
    logic        irq, irq5, irq32;

    always #5 clk = ~clk;

    avalon_gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .port_i(port_i), .port_o(port_o), .port_oe(port_oe), .irq(irq)
    );

    avalon_gpio_port #(.WIDTH(5), .SYNC_STAGES(S)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd5),
        .port_i(port_i[4:0]), .port_o(port_o5), .port_oe(port_oe5), .irq(irq5)
    );

    avalon_gpio_port #(.WIDTH(32), .SYNC_STAGES(S)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd32),
        .port_i({24'h0, port_i}), .port_o(port_o32), .port_oe(port_oe32), .irq(irq32)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: PIN is the port_i sample from S clocks ago; an edge exists between two consecutive
    // post-reset samples.
    logic [W-1:0]  m_dir = '0, m_port = '0, m_mask = '0, m_sel = '0, m_cap = '0;
    logic [31:0]   m_rd  = '0;
    logic          m_irq = 1'b0;
    logic [W-1:0]  samples[$];

    always @(posedge clk or negedge reset_n) begin : model
        int           n;
        logic [W-1:0] pin, prev, edges, wd, w1c, rd;
        if (!reset_n) begin
            m_dir  <= '0;
            m_port <= '0;
            m_mask <= '0;
            m_sel  <= '0;
            m_cap  <= '0;
            m_rd   <= '0;
            m_irq  <= 1'b0;
            samples.delete();
        end else begin
            n     = samples.size();
            pin   = (n >= S) ? samples[n-S] : '0;
            prev  = (n >= S + 1) ? samples[n-S-1] : '0;
            edges = '0;
            if (n >= S + 1) edges = (m_sel & prev & ~pin) | (~m_sel & pin & ~prev);
            wd  = avs_writedata[W-1:0];
            w1c = '0;
            if (avs_read) begin
                case (avs_address)
                    REG_DIR:      rd = m_dir;
                    REG_PIN:      rd = pin;
                    REG_PORT:     rd = m_port;
`ifdef GPIO_PORT_IRQ_EN
                    REG_IRQ_MASK: rd = m_mask;
`endif
                    REG_EDGE_CAP: rd = m_cap;
                    REG_EDGE_SEL: rd = m_sel;
                    default:      rd = '0;
                endcase
                m_rd <= {24'h0, rd};
            end
`ifdef GPIO_PORT_IRQ_EN
            m_irq <= |(m_cap & m_mask);
`endif
            if (avs_write) begin
                case (avs_address)
                    REG_DIR:      m_dir  <= wd;
                    REG_PORT:     m_port <= wd;
                    REG_SET:      m_port <= m_port | wd;
                    REG_CLR:      m_port <= m_port & ~wd;
`ifdef GPIO_PORT_IRQ_EN
                    REG_IRQ_MASK: m_mask <= wd;
`endif
                    REG_EDGE_CAP: w1c = wd;
                    REG_EDGE_SEL: m_sel  <= wd;
                    default:      ;
                endcase
            end
            m_cap <= (m_cap & ~w1c) | edges;
            samples.push_back(port_i);
            if (samples.size() > S + 1) samples.pop_front();
        end
    end

    always @(negedge clk) begin
        check("cycle port_o", 32'(port_o), 32'(m_port));
        check("cycle port_oe", 32'(port_oe), 32'(m_dir));
        check("cycle readdata", avs_readdata, m_rd);
        check("cycle irq", 32'(irq), 32'(m_irq));
    end

    // Bus tasks start at a negedge and return at the following negedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic bus_rw(input logic [2:0] a, input logic [31:0] wdat, output logic [31:0] d);
        avs_address = a; avs_writedata = wdat; avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        d = avs_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] d;
    int          first_ff;

    initial begin
        port_i = 8'hFF;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset port_o", 32'(port_o), 32'h0);
        check("reset port_oe", 32'(port_oe), 32'h0);
        check("reset readdata", avs_readdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Pins high through reset: PIN fills after S+1 cycles, no capture.
        first_ff = -1;
        for (int i = 0; i < 8; i++) begin
            bus_read(REG_PIN, d);
            if (first_ff < 0 && d == 32'hFF) first_ff = i;
        end
        check("pin fill latency", 32'(first_ff), 32'(S));
        bus_read(REG_EDGE_CAP, d);
        check("no capture at prime", d, 32'h0);
        check("irq after prime", 32'(irq), 32'h0);

        // Direction, latch and atomic SET/CLR.
        bus_write(REG_DIR, 32'h0F);
        bus_write(REG_PORT, 32'hA5);
        bus_write(REG_SET, 32'h10);
        bus_write(REG_CLR, 32'h01);
        check("port_oe 0F", 32'(port_oe), 32'h0F);
        check("port_o B4", 32'(port_o), 32'hB4);
        bus_read(REG_SET, d);
        check("SET reads 0", d, 32'h0);
        bus_read(REG_CLR, d);
        check("CLR reads 0", d, 32'h0);
        bus_read(REG_PORT, d);
        check("PORT readback", d, 32'hB4);

        // Rising edge on bit 0 with IRQ mask.
        bus_write(REG_EDGE_SEL, 32'h0);
        bus_write(REG_IRQ_MASK, 32'h01);
        bus_read(REG_IRQ_MASK, d);
`ifdef GPIO_PORT_IRQ_EN
        check("IRQ_MASK readback", d, 32'h01);
`else
        check("IRQ_MASK reads 0", d, 32'h0);
`endif
        port_i = 8'hFE;
        idle(5);
        bus_read(REG_EDGE_CAP, d);
        check("falling ignored sel0", d, 32'h0);
        port_i = 8'hFF;
        idle(2);
        bus_read(REG_EDGE_CAP, d);
        check("cap before S+1", d, 32'h0);
        bus_read(REG_EDGE_CAP, d);
        check("cap at S+1", d, 32'h01);
`ifdef GPIO_PORT_IRQ_EN
        check("irq raised", 32'(irq), 32'h1);
`else
        check("irq stays low", 32'(irq), 32'h0);
`endif
        bus_write(REG_EDGE_CAP, 32'h01);
        idle(1);
        check("irq after w1c", 32'(irq), 32'h0);
        bus_read(REG_EDGE_CAP, d);
        check("cap cleared", d, 32'h0);

        // Falling edge on bit 2 colliding with W1C.
        bus_write(REG_EDGE_SEL, 32'h04);
        port_i = 8'hFB;
        idle(4);
        bus_read(REG_EDGE_CAP, d);
        check("fall bit2", d, 32'h04);
        port_i = 8'hFF;
        idle(4);
        bus_read(REG_EDGE_CAP, d);
        check("rise bit2 ignored", d, 32'h04);
        port_i = 8'hFB;
        idle(2);
        bus_write(REG_EDGE_CAP, 32'h04);
        bus_read(REG_EDGE_CAP, d);
        check("set dominates w1c", d, 32'h04);
        bus_write(REG_EDGE_CAP, 32'h04);
        bus_read(REG_EDGE_CAP, d);
        check("plain w1c", d, 32'h0);

        // Simultaneous read and write returns the old value.
        bus_rw(REG_PORT, 32'h3C, d);
        check("rw old value", d, 32'hB4);
        check("rw new port_o", 32'(port_o), 32'h3C);

        // Width clipping on 5- and 32-bit instances.
        bus_write(REG_PORT, 32'hFFFF_FFFF);
        check("w8 port_o", 32'(port_o), 32'hFF);
        check("w32 port_o", port_o32, 32'hFFFF_FFFF);
        check("w5 port_o", 32'(port_o5), 32'h1F);
        bus_read(REG_PORT, d);
        check("w8 readback", d, 32'hFF);
        check("w5 readback", rd5, 32'h0000_001F);
        check("w32 readback", rd32, 32'hFFFF_FFFF);

        // Reset mid-burst with state and irq up.
        bus_write(REG_IRQ_MASK, 32'h04);
        port_i = 8'hFF;
        idle(4);
        port_i = 8'hFB;
        idle(5);
`ifdef GPIO_PORT_IRQ_EN
        check("irq before reset", 32'(irq), 32'h1);
`endif
        avs_address = REG_PORT;
        avs_read    = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async port_o", 32'(port_o), 32'h0);
        check("async port_oe", 32'(port_oe), 32'h0);
        check("async readdata", avs_readdata, 32'h0);
        check("async irq", 32'(irq), 32'h0);
        @(negedge clk);
        avs_read = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(6);
        bus_read(REG_DIR, d);
        check("DIR after reset", d, 32'h0);
        bus_read(REG_EDGE_CAP, d);
        check("CAP after reset", d, 32'h0);
        bus_read(REG_EDGE_SEL, d);
        check("SEL after reset", d, 32'h0);
        bus_read(REG_IRQ_MASK, d);
        check("MASK after reset", d, 32'h0);
        bus_read(REG_PIN, d);
        check("PIN after reset", d, 32'hFB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
